// File: rtl/grn_node_multi.sv
// rtl/grn_node_multi.sv - multi-channel boolean GRN node with per-channel step divider
// Optional stability counter enabled by defining GRN_STABLE_CNT_EN.
module grn_node_multi #(
    parameter int N_CH   = 2,
    parameter int N_IN   = 2,
    parameter int DIV_W  = 4,
    parameter int STAB_W = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    reset_nos,
    input  logic                    init_state,
    input  logic [N_CH-1:0]         start,
    input  logic [N_CH*DIV_W-1:0]   div_cfg,
    input  logic                    mode,
    input  logic [N_IN-1:0]         neg_mask,
    input  logic [N_CH*N_IN-1:0]    reg_in,
    output logic [N_CH-1:0]         s,
    output logic [N_CH-1:0]         updated,
    output logic [N_CH-1:0]         changed,
    output logic [N_CH-1:0]         stable
);

    logic [N_CH-1:0]  r_s;
    logic [N_CH-1:0]  r_updated;
    logic [N_CH-1:0]  r_changed;
    logic [DIV_W-1:0] r_cnt [N_CH];

    logic [N_CH-1:0]  w_f;
    logic [N_CH-1:0]  w_eval;
    logic [N_CH-1:0]  w_diff;

    // A channel evaluates only when its divider has run down to zero.
    always_comb begin
        w_f    = '0;
        w_eval = '0;
        w_diff = '0;
        for (int c = 0; c < N_CH; c++) begin
            w_f[c]    = mode ? (&(reg_in[c*N_IN +: N_IN] ^ neg_mask))
                             : (|(reg_in[c*N_IN +: N_IN] ^ neg_mask));
            w_eval[c] = start[c] && (r_cnt[c] == '0);
            w_diff[c] = w_f[c] != r_s[c];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s       <= '0;
            r_updated <= '0;
            r_changed <= '0;
            for (int c = 0; c < N_CH; c++) begin
                r_cnt[c] <= '0;
            end
        end else if (reset_nos) begin
            r_s       <= {N_CH{init_state}};
            r_updated <= '0;
            r_changed <= '0;
            for (int c = 0; c < N_CH; c++) begin
                r_cnt[c] <= '0;
            end
        end else begin
            for (int c = 0; c < N_CH; c++) begin
                r_updated[c] <= w_eval[c];
                r_changed[c] <= w_eval[c] && w_diff[c];
                if (w_eval[c]) begin
                    r_s[c]   <= w_f[c];
                    r_cnt[c] <= div_cfg[c*DIV_W +: DIV_W];
                end else if (start[c]) begin
                    r_cnt[c] <= r_cnt[c] - DIV_W'(1);
                end
            end
        end
    end

    assign s       = r_s;
    assign updated = r_updated;
    assign changed = r_changed;

`ifdef GRN_STABLE_CNT_EN
    localparam logic [STAB_W-1:0] STAB_MAX = {STAB_W{1'b1}};

    logic [STAB_W-1:0] r_stab [N_CH];

    // Counts consecutive evaluations that left the state unchanged, saturating.
    always_ff @(posedge clk) begin
        if (rst || reset_nos) begin
            for (int c = 0; c < N_CH; c++) begin
                r_stab[c] <= '0;
            end
        end else begin
            for (int c = 0; c < N_CH; c++) begin
                if (w_eval[c]) begin
                    if (w_diff[c]) begin
                        r_stab[c] <= '0;
                    end else if (r_stab[c] != STAB_MAX) begin
                        r_stab[c] <= r_stab[c] + STAB_W'(1);
                    end
                end
            end
        end
    end

    always_comb begin
        stable = '0;
        for (int c = 0; c < N_CH; c++) begin
            stable[c] = (r_stab[c] == STAB_MAX);
        end
    end
`else
    localparam logic [STAB_W-1:0] STAB_ZERO = '0;

    assign stable = {N_CH{&STAB_ZERO}};
`endif

endmodule

// File: tb/tb_grn_node_multi.sv
// tb/tb_grn_node_multi.sv - directed and randomized checks of grn_node_multi against a reference model
module tb_grn_node_multi;

    localparam int N_CH  = 2;
    localparam int N_IN  = 2;
    localparam int DIV_W = 4;
`ifdef GRN_STABLE_CNT_EN
    localparam int STAB_W = 2;
`else
    localparam int STAB_W = 8;
`endif

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  reset_nos;
    logic                  init_state;
    logic [N_CH-1:0]       start;
    logic [N_CH*DIV_W-1:0] div_cfg;
    logic                  mode;
    logic [N_IN-1:0]       neg_mask;
    logic [N_CH*N_IN-1:0]  reg_in;
    logic [N_CH-1:0]       s;
    logic [N_CH-1:0]       updated;
    logic [N_CH-1:0]       changed;
    logic [N_CH-1:0]       stable;

    int n_vec  = 0;
    int n_fail = 0;

    int m_s    [N_CH];
    int m_cnt  [N_CH];
    int m_upd  [N_CH];
    int m_chg  [N_CH];
    int m_stab [N_CH];

    always #5 clk = ~clk;

    grn_node_multi #(
        .N_CH   (N_CH),
        .N_IN   (N_IN),
        .DIV_W  (DIV_W),
        .STAB_W (STAB_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .reset_nos  (reset_nos),
        .init_state (init_state),
        .start      (start),
        .div_cfg    (div_cfg),
        .mode       (mode),
        .neg_mask   (neg_mask),
        .reg_in     (reg_in),
        .s          (s),
        .updated    (updated),
        .changed    (changed),
        .stable     (stable)
    );

    function automatic int ref_f(int c);
        int ones;
        ones = 0;
        for (int i = 0; i < N_IN; i++) begin
            if (reg_in[c*N_IN + i] != neg_mask[i]) ones++;
        end
        return mode ? int'(ones == N_IN) : int'(ones > 0);
    endfunction

    task automatic model_edge();
        int nf;
        int stab_max;
        stab_max = (1 << STAB_W) - 1;
        for (int c = 0; c < N_CH; c++) begin
            if (rst) begin
                m_s[c] = 0; m_cnt[c] = 0; m_upd[c] = 0; m_chg[c] = 0; m_stab[c] = 0;
            end else if (reset_nos) begin
                m_s[c] = int'(init_state); m_cnt[c] = 0; m_upd[c] = 0; m_chg[c] = 0; m_stab[c] = 0;
            end else if (start[c]) begin
                if (m_cnt[c] == 0) begin
                    nf       = ref_f(c);
                    m_chg[c] = int'(nf != m_s[c]);
                    m_upd[c] = 1;
                    if (m_chg[c] != 0) m_stab[c] = 0;
                    else if (m_stab[c] < stab_max) m_stab[c] = m_stab[c] + 1;
                    m_s[c]   = nf;
                    m_cnt[c] = int'(div_cfg[c*DIV_W +: DIV_W]);
                end else begin
                    m_cnt[c] = m_cnt[c] - 1;
                    m_upd[c] = 0;
                    m_chg[c] = 0;
                end
            end else begin
                m_upd[c] = 0;
                m_chg[c] = 0;
            end
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        logic [N_CH-1:0] e_s, e_u, e_c, e_st;
        @(posedge clk);
        model_edge();
        #1;
        e_s = '0; e_u = '0; e_c = '0; e_st = '0;
        for (int c = 0; c < N_CH; c++) begin
            e_s[c] = m_s[c][0];
            e_u[c] = m_upd[c][0];
            e_c[c] = m_chg[c][0];
`ifdef GRN_STABLE_CNT_EN
            e_st[c] = (m_stab[c] == (1 << STAB_W) - 1);
`endif
        end
        check("model_s",       32'(s),       32'(e_s));
        check("model_updated", 32'(updated), 32'(e_u));
        check("model_changed", 32'(changed), 32'(e_c));
        check("model_stable",  32'(stable),  32'(e_st));
    endtask

    initial begin
        int upd_count;
        rst = 1'b1; reset_nos = 1'b0; init_state = 1'b0; start = '0;
        div_cfg = '0; mode = 1'b0; neg_mask = '0; reg_in = '0;
        for (int c = 0; c < N_CH; c++) begin
            m_s[c] = 0; m_cnt[c] = 0; m_upd[c] = 0; m_chg[c] = 0; m_stab[c] = 0;
        end

        // reset state held for ten idle cycles
        step(); step();
        rst = 1'b0;
        repeat (10) step();
        check("reset_s", 32'(s), 32'(0));
        check("reset_strobes", 32'({updated, changed, stable}), 32'(0));

        // re-initialise to ones, then channel 0 evaluates OR of 00
        reset_nos = 1'b1; init_state = 1'b1;
        step();
        reset_nos = 1'b0; reg_in = 4'b0100; start = 2'b01;
        step();
        start = '0;
        check("t2_s", 32'(s), 32'(2'b10));
        check("t2_updated", 32'(updated), 32'(2'b01));
        check("t2_changed", 32'(changed), 32'(2'b01));

        // divide-by-two on channel 0: four starts give two updates
        div_cfg[0 +: DIV_W] = 4'd1; reg_in[1:0] = 2'b11;
        upd_count = 0;
        for (int k = 0; k < 4; k++) begin
            start = 2'b01;
            step();
            if (updated[0]) upd_count++;
        end
        start = '0;
        check("t3_update_count", 32'(upd_count), 32'(2));
        check("t3_s0", 32'(s[0]), 32'(1));

        // AND mode with inhibitor on input 0
        mode = 1'b1; neg_mask = 2'b01; reg_in[3:2] = 2'b10; start = 2'b10;
        step();
        check("t4_s1_on", 32'(s[1]), 32'(1));
        reg_in[3:2] = 2'b11;
        step();
        start = '0;
        check("t4_s1_off", 32'(s[1]), 32'(0));
        check("t4_changed1", 32'(changed[1]), 32'(1));

        // priority: rst over reset_nos over start
        rst = 1'b1; reset_nos = 1'b1; start = 2'b11;
        step();
        check("t5_rst_wins", 32'(s), 32'(0));
        rst = 1'b0; init_state = 1'b1;
        step();
        check("t5_nos_s", 32'(s), 32'(2'b11));
        check("t5_nos_updated", 32'(updated), 32'(0));
        reset_nos = 1'b0; start = '0;
        step();

`ifdef GRN_STABLE_CNT_EN
        // three unchanged updates saturate a 2-bit counter
        reset_nos = 1'b1; init_state = 1'b0;
        step();
        reset_nos = 1'b0; mode = 1'b0; neg_mask = '0; reg_in = '0; div_cfg = '0; start = 2'b11;
        repeat (3) step();
        check("t6_stable_set", 32'(stable), 32'(2'b11));
        reg_in = '1;
        step();
        start = '0;
        check("t6_stable_clear", 32'(stable), 32'(2'b00));
`endif

        // randomized phase
        for (int k = 0; k < 3000; k++) begin
            rst        = ($urandom_range(0, 199) == 0);
            reset_nos  = ($urandom_range(0, 39) == 0);
            init_state = 1'($urandom);
            start      = N_CH'($urandom);
            mode       = 1'($urandom);
            neg_mask   = N_IN'($urandom);
            reg_in     = (N_CH*N_IN)'($urandom);
            if ($urandom_range(0, 7) == 0) begin
                for (int c = 0; c < N_CH; c++) begin
                    div_cfg[c*DIV_W +: DIV_W] = DIV_W'($urandom_range(0, 3));
                end
            end
            step();
        end

        rst = 1'b0; reset_nos = 1'b0; start = '0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
